// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: captures UART receiver bytes into a FIFO, acks the receiver, tracks error status
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [7:0]         RxDataOutput,
    input  logic               RxReady,
    input  logic               RxError,
    output logic               RxEnable,
    output logic [7:0]         DataOut,
    output logic               DataValid,
    input  logic               DataRead,
    output logic [LEVEL_W-1:0] Level,
    output logic               Overrun,
    output logic [7:0]         ErrorCount,
    input  logic               ClearFlags
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] count;
    logic               err_prev;
    logic               full;
    logic               wr;
    logic               rd;
    logic               err_rise;

    // Full is judged on the occupancy before the edge, so a same-cycle read never makes room
    assign full      = count == LEVEL_W'(DEPTH);
    assign wr        = state == IDLE && RxReady && !full;
    assign DataValid = count != '0;
    assign rd        = DataValid && DataRead;
    assign err_rise  = RxError && !err_prev;
    assign DataOut   = DataValid ? mem[rd_ptr] : 8'h00;
    assign Level     = count;

    // Capture handshake: one write per byte, one-cycle ack, then wait for the receiver to drop ready
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            RxEnable <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    RxEnable <= wr;
                    state    <= wr ? ACK : IDLE;
                end
                ACK: begin
                    RxEnable <= 1'b0;
                    state    <= WAIT_LOW;
                end
                default: begin
                    RxEnable <= 1'b0;
                    state    <= RxReady ? WAIT_LOW : IDLE;
                end
            endcase
        end
    end

    // Storage array; contents need no reset because the head is masked while empty
    always_ff @(posedge Clk) begin
        if (wr)
            mem[wr_ptr] <= RxDataOutput;
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks writes minus reads
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr ? wr_ptr + PTR_W'(1) : wr_ptr;
            rd_ptr <= rd ? rd_ptr + PTR_W'(1) : rd_ptr;
            count  <= count + LEVEL_W'(wr) - LEVEL_W'(rd);
        end
    end

    // Error edge detection, saturating error count and sticky overrun; a clear wins over a set
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            err_prev   <= 1'b0;
            ErrorCount <= 8'h00;
            Overrun    <= 1'b0;
        end else begin
            err_prev   <= RxError;
            ErrorCount <= ClearFlags ? 8'h00 : ErrorCount + 8'(err_rise && ErrorCount != 8'hFF);
            Overrun    <= !ClearFlags && (Overrun || (err_rise && state == IDLE && RxReady && full));
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: vector table, directed corner sequences and a randomized queue-model run
module tb_uart_rx_fifo;
    logic       Clk;
    logic       Reset;
    logic [7:0] RxDataOutput;
    logic       RxReady;
    logic       RxError;
    logic       RxEnable;
    logic [7:0] DataOut;
    logic       DataValid;
    logic       DataRead;
    logic [4:0] Level;
    logic       Overrun;
    logic [7:0] ErrorCount;
    logic       ClearFlags;

    int total = 0;
    int bad = 0;

    uart_rx_fifo #(.DEPTH(16)) dut (
        .Clk(Clk), .Reset(Reset), .RxDataOutput(RxDataOutput), .RxReady(RxReady),
        .RxError(RxError), .RxEnable(RxEnable), .DataOut(DataOut), .DataValid(DataValid),
        .DataRead(DataRead), .Level(Level), .Overrun(Overrun), .ErrorCount(ErrorCount),
        .ClearFlags(ClearFlags)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic       err;
        logic       rd;
        logic       clr;
        logic       en;
        logic       vld;
        logic [7:0] dout;
        logic [4:0] lvl;
        logic       ovr;
        logic [7:0] ecnt;
    } vec_t;

    vec_t tbl [19];

    logic [7:0] q [$];
    int         ecnt_m;
    bit         ovr_m;
    bit         errp_m;
    int         gap;
    logic       rdy_s, err_s, rd_s, clr_s, cap;
    logic [7:0] d_s;
    int         pre;
    int         rp;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rdy, input logic [7:0] d, input logic err, input logic rd, input logic clr);
        RxReady = rdy;
        RxDataOutput = d;
        RxError = err;
        DataRead = rd;
        ClearFlags = clr;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset;
        Reset = 1'b0;
        RxReady = 1'b0;
        RxDataOutput = 8'h00;
        RxError = 1'b0;
        DataRead = 1'b0;
        ClearFlags = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
    endtask

    task automatic fill(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            step(1'b1, base + 8'(i), 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        //          rdy  d      err rd  clr   en  vld dout   lvl ovr ecnt
        tbl[0]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd1, 1'b0, 8'd0};
        tbl[1]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 8'd0};
        tbl[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 8'd0};
        tbl[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 8'd0};
        tbl[4]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 8'd0};
        tbl[5]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 8'd0};
        tbl[6]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 5'd1, 1'b0, 8'd0};
        tbl[7]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 5'd2, 1'b0, 8'd0};
        tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 8'd0};
        tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 8'd1};
        tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h3C, 5'd1, 1'b0, 8'd0};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd0};
        tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd0};
        tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd0};
        tbl[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0, 1'b0, 8'd1};
        tbl[17] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h77, 5'd1, 1'b0, 8'd1};
        tbl[18] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h77, 5'd1, 1'b0, 8'd1};

        do_reset;
        chk("rst_en", RxEnable, 0);
        chk("rst_vld", DataValid, 0);
        chk("rst_dout", DataOut, 8'h00);
        chk("rst_lvl", Level, 0);
        chk("rst_ovr", Overrun, 0);
        chk("rst_ecnt", ErrorCount, 0);

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rdy, tbl[i].d, tbl[i].err, tbl[i].rd, tbl[i].clr);
            chk($sformatf("v%0d_en", i), RxEnable, tbl[i].en);
            chk($sformatf("v%0d_vld", i), DataValid, tbl[i].vld);
            chk($sformatf("v%0d_dout", i), DataOut, tbl[i].dout);
            chk($sformatf("v%0d_lvl", i), Level, tbl[i].lvl);
            chk($sformatf("v%0d_ovr", i), Overrun, tbl[i].ovr);
            chk($sformatf("v%0d_ecnt", i), ErrorCount, tbl[i].ecnt);
        end

        // full FIFO holds the byte off until a read has completed
        do_reset;
        fill(16, 8'h00);
        chk("full_lvl", Level, 16);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
            chk("full_noack", RxEnable, 0);
            chk("full_hold", Level, 16);
        end
        chk("full_head", DataOut, 8'h00);
        step(1'b1, 8'h10, 1'b0, 1'b1, 1'b0);
        chk("full_rd_noack", RxEnable, 0);
        chk("full_rd_lvl", Level, 15);
        chk("full_rd_head", DataOut, 8'h01);
        step(1'b1, 8'h10, 1'b0, 1'b0, 1'b0);
        chk("full_cap_ack", RxEnable, 1);
        chk("full_cap_lvl", Level, 16);
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d", k), DataOut, k + 1);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_lvl", Level, 0);
        chk("drain_vld", DataValid, 0);

        // overrun on error while stalled on a full FIFO, then cleared
        do_reset;
        fill(16, 8'h40);
        step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("ovr_pre", Overrun, 0);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
        chk("ovr_set", Overrun, 1);
        chk("ovr_ecnt", ErrorCount, 1);
        step(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
        chk("ovr_clr", Overrun, 0);
        chk("ovr_ecnt_clr", ErrorCount, 0);

        // error counter saturation
        do_reset;
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            if (i == 253) chk("sat_254", ErrorCount, 8'hFE);
        end
        chk("sat_ff", ErrorCount, 8'hFF);

        // reset in the middle of an ack with three entries stored
        do_reset;
        fill(2, 8'h11);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        chk("mid_en", RxEnable, 1);
        chk("mid_lvl", Level, 3);
        Reset = 1'b0;
        #1;
        chk("mid_rst_en", RxEnable, 0);
        chk("mid_rst_lvl", Level, 0);
        chk("mid_rst_vld", DataValid, 0);
        RxReady = 1'b0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        chk("post_en", RxEnable, 1);
        chk("post_lvl", Level, 1);
        chk("post_dout", DataOut, 8'h5A);

        // randomized traffic against a queue model; the driver behaves like a real receiver
        do_reset;
        q.delete();
        ecnt_m = 0;
        ovr_m = 0;
        errp_m = 0;
        gap = 0;
        for (int i = 0; i < 4000; i++) begin
            rp = ((i / 400) % 2) != 0 ? 5 : 65;
            DataRead = $urandom_range(0, 99) < rp;
            if ($urandom_range(0, 24) == 0) RxError = ~RxError;
            ClearFlags = $urandom_range(0, 59) == 0;
            rdy_s = RxReady;
            d_s = RxDataOutput;
            err_s = RxError;
            rd_s = DataRead;
            clr_s = ClearFlags;
            @(posedge Clk);
            pre = q.size();
            cap = rdy_s && pre < 16;
            ovr_m = !clr_s && (ovr_m || (err_s && !errp_m && rdy_s && pre == 16));
            ecnt_m = clr_s ? 0 : (err_s && !errp_m && ecnt_m < 255) ? ecnt_m + 1 : ecnt_m;
            errp_m = err_s;
            if (rd_s && pre > 0) void'(q.pop_front());
            if (cap) q.push_back(d_s);
            #1;
            chk("r_en", RxEnable, cap);
            chk("r_lvl", Level, q.size());
            chk("r_vld", DataValid, q.size() != 0);
            chk("r_dout", DataOut, q.size() != 0 ? q[0] : 8'h00);
            chk("r_ovr", Overrun, ovr_m);
            chk("r_ecnt", ErrorCount, ecnt_m);
            if (RxReady && RxEnable) begin
                RxReady = 1'b0;
                gap = $urandom_range(2, 4);
            end else if (!RxReady) begin
                if (gap != 0) gap--;
                else if ($urandom_range(0, 1) == 1) begin
                    RxReady = 1'b1;
                    RxDataOutput = 8'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
